// File: rtl/duty_cycle_calc_pkg.sv
// -----------------------------------------------------------------------------
// duty_meter_pkg
// Shared definitions for the duty-cycle calculator:
//   - default count width, full-scale value and result width
//   - controller state encoding
//   - calc_num_w(): numerator width needed for cnt * scale (plus the rounding
//     bit when DUTY_CYCLE_CALC_ROUND_EN is defined)
// -----------------------------------------------------------------------------
package duty_meter_pkg;

   localparam int unsigned CNT_W_DEF  = 32;
   localparam int unsigned SCALE_DEF  = 1000;
   localparam int unsigned DUTY_W_DEF = 10;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DIV,
      DONE
   } state_e;

   // Bits needed to hold cnt * scale. The rounding build adds den/2 to the
   // numerator, which can carry into one more bit.
   function automatic int unsigned calc_num_w(input int unsigned cnt_w,
                                              input int unsigned scale);
      int unsigned w;
      w = cnt_w + $clog2(scale + 1);
`ifdef DUTY_CYCLE_CALC_ROUND_EN
      w = w + 1;
`endif
      return w;
   endfunction

endpackage

// File: rtl/duty_cycle_calc_if.sv
// -----------------------------------------------------------------------------
// duty_cycle_calc_if
// Bundle between the duty-cycle meter (master: supplies counts, consumes
// results) and the calculator (slave).
//   high_cnt, low_cnt : buffered high/low time counts      (master -> slave)
//   duty_out          : last computed duty                 (slave -> master)
//   duty_valid        : one-cycle strobe on duty_out update (slave -> master)
//   div_zero          : last result had a zero denominator (slave -> master)
//   busy              : calculation in progress            (slave -> master)
// -----------------------------------------------------------------------------
interface duty_cycle_calc_if
   import duty_meter_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned DUTY_W = DUTY_W_DEF
);

   logic [CNT_W-1:0]  high_cnt;
   logic [CNT_W-1:0]  low_cnt;
   logic [DUTY_W-1:0] duty_out;
   logic              duty_valid;
   logic              div_zero;
   logic              busy;

   modport master (
      output high_cnt, low_cnt,
      input  duty_out, duty_valid, div_zero, busy
   );

   modport slave (
      input  high_cnt, low_cnt,
      output duty_out, duty_valid, div_zero, busy
   );

endinterface

// File: rtl/duty_cycle_calc_serial_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Synchronous active-high reset.
//   clk_i, rst_i : clock / synchronous reset
//   start_i      : load num_i/den_i and begin (den_i must be non-zero)
//   num_i, den_i : dividend / divisor, sampled on start_i
//   busy_o       : iterations in progress
//   done_o       : high during the cycle whose edge completes the last step;
//                  quot_o is final after that edge
//   quot_o       : quotient
// -----------------------------------------------------------------------------
module serial_divider #(
   parameter int unsigned NUM_W = 42,
   parameter int unsigned DEN_W = 33
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [NUM_W-1:0] num_i,
   input  logic [DEN_W-1:0] den_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [NUM_W-1:0] quot_o
);

   localparam int unsigned CTR_W = $clog2(NUM_W + 1);

   logic [NUM_W-1:0] num_q, num_d;
   logic [NUM_W-1:0] quot_q, quot_d;
   logic [DEN_W-1:0] den_q, den_d;
   logic [DEN_W-1:0] rem_q, rem_d;
   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic             busy_q, busy_d;

   // Partial remainder with the next numerator bit appended. Since rem < den,
   // trial < 2*den and the restored value always fits back into DEN_W bits.
   logic [DEN_W:0]   trial;
   logic             fits;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned - that is what keeps combinational blocks latch-free.
      num_d  = num_q;
      quot_d = quot_q;
      den_d  = den_q;
      rem_d  = rem_q;
      ctr_d  = ctr_q;
      busy_d = busy_q;
      trial  = {rem_q, num_q[NUM_W-1]};
      fits   = (trial >= {1'b0, den_q});

      if (start_i) begin
         num_d  = num_i;
         den_d  = den_i;
         rem_d  = '0;
         quot_d = '0;
         ctr_d  = CTR_W'(NUM_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         num_d = num_q << 1;
         if (fits) begin
            // Modular subtraction is exact here: the true result is < den.
            rem_d  = trial[DEN_W-1:0] - den_q;
            quot_d = {quot_q[NUM_W-2:0], 1'b1};
         end else begin
            rem_d  = trial[DEN_W-1:0];
            quot_d = {quot_q[NUM_W-2:0], 1'b0};
         end
         ctr_d = ctr_q - CTR_W'(1);
         if (ctr_q == CTR_W'(1)) begin
            busy_d = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         num_q  <= '0;
         quot_q <= '0;
         den_q  <= '0;
         rem_q  <= '0;
         ctr_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         num_q  <= num_d;
         quot_q <= quot_d;
         den_q  <= den_d;
         rem_q  <= rem_d;
         ctr_q  <= ctr_d;
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (ctr_q == CTR_W'(1));
   assign quot_o = quot_q;

endmodule

// File: rtl/duty_cycle_calc.sv
// -----------------------------------------------------------------------------
// duty_cycle_calc
// Watches the meter's high/low count pair; on every change computes
//    duty = high * SCALE / (high + low)
// with a serial divider and presents it as a registered value plus a
// one-cycle valid strobe. Synchronous active-high reset.
//   sys_clk : system clock (rising edge)
//   rst     : synchronous active-high reset
//   bus     : duty_cycle_calc_if.slave
//             high_cnt/low_cnt in; duty_out, duty_valid, div_zero, busy out
// Build option: DUTY_CYCLE_CALC_ROUND_EN - round to nearest (ties up)
// instead of truncating; adds one divider step.
// -----------------------------------------------------------------------------
module duty_cycle_calc
   import duty_meter_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned SCALE  = SCALE_DEF,
   parameter int unsigned DUTY_W = DUTY_W_DEF
) (
   input  logic               sys_clk,
   input  logic               rst,
   duty_cycle_calc_if.slave   bus
);

   localparam int unsigned NUM_W = calc_num_w(CNT_W, SCALE);
   localparam int unsigned DEN_W = CNT_W + 1;
   localparam logic [NUM_W-1:0] SAT_MAX = {{(NUM_W - DUTY_W){1'b0}}, {DUTY_W{1'b1}}};

   state_e state_q, state_d;

   logic [CNT_W-1:0]  cap_hi_q, cap_hi_d;
   logic [CNT_W-1:0]  cap_lo_q, cap_lo_d;
   logic              zero_q, zero_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              valid_q, valid_d;
   logic              div_zero_q, div_zero_d;

   logic              pair_changed;
   logic [DEN_W-1:0]  load_den;
   logic [NUM_W-1:0]  load_num;

   logic              div_start;
   logic              div_busy;
   logic              div_done;
   logic [NUM_W-1:0]  div_quot;
   logic              busy;

   assign pair_changed = ({bus.high_cnt, bus.low_cnt} != {cap_hi_q, cap_lo_q});

   // One extra bit on the sum so high + low can never wrap.
   assign load_den = {1'b0, cap_hi_q} + {1'b0, cap_lo_q};

`ifdef DUTY_CYCLE_CALC_ROUND_EN
   // Adding den/2 before truncating division rounds to nearest, ties up.
   assign load_num = NUM_W'(cap_hi_q) * NUM_W'(SCALE) + NUM_W'(load_den >> 1);
`else
   assign load_num = NUM_W'(cap_hi_q) * NUM_W'(SCALE);
`endif

   serial_divider #(
      .NUM_W (NUM_W),
      .DEN_W (DEN_W)
   ) u_div (
      .clk_i   (sys_clk),
      .rst_i   (rst),
      .start_i (div_start),
      .num_i   (load_num),
      .den_i   (load_den),
      .busy_o  (div_busy),
      .done_o  (div_done),
      .quot_o  (div_quot)
   );

   // ---------------------------------------------------------------- FSM --
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (pair_changed) state_d = LOAD;
         LOAD: state_d = (load_den == '0) ? DONE : DIV;
         DIV:  if (div_done) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      div_start = (state_q == LOAD) && (load_den != '0);
      busy      = (state_q == LOAD) || ((state_q == DIV) && div_busy);
   end

   // ----------------------------------------------------------- datapath --
   always_comb begin
      cap_hi_d   = cap_hi_q;
      cap_lo_d   = cap_lo_q;
      zero_d     = zero_q;
      duty_d     = duty_q;
      div_zero_d = div_zero_q;
      valid_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pair_changed) begin
               cap_hi_d = bus.high_cnt;
               cap_lo_d = bus.low_cnt;
            end
         end
         LOAD: zero_d = (load_den == '0);
         DONE: begin
            // The divider never ran for a zero denominator, so its quotient
            // is stale; force 0 instead. Saturation only guards high > high+low.
            if (zero_q) begin
               duty_d = '0;
            end else if (div_quot > SAT_MAX) begin
               duty_d = '1;
            end else begin
               duty_d = div_quot[DUTY_W-1:0];
            end
            div_zero_d = zero_q;
            valid_d    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         cap_hi_q   <= '0;
         cap_lo_q   <= '0;
         zero_q     <= 1'b0;
         duty_q     <= '0;
         valid_q    <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         cap_hi_q   <= cap_hi_d;
         cap_lo_q   <= cap_lo_d;
         zero_q     <= zero_d;
         duty_q     <= duty_d;
         valid_q    <= valid_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.duty_out   = duty_q;
   assign bus.duty_valid = valid_q;
   assign bus.div_zero   = div_zero_q;
   assign bus.busy       = busy;

endmodule

// File: doc/duty_cycle_calc.md
# duty_cycle_calc

Downstream consumer of the duty-cycle meter's buffered counts. It watches the `high_cnt`/`low_cnt` pair, and whenever the pair changes it computes duty = high·SCALE/(high+low) with a serial restoring divider. It presents the result as a registered value with a one-cycle valid strobe for the display/UART stage. It runs in the `sys_clk` domain alongside the meter.

## Interface
- `CNT_W`, 32: width of each input count.
- `SCALE`, 1000: full-scale result; the default gives permille.
- `DUTY_W`, 10: result width; must hold SCALE.
- `sys_clk  in  1`: system clock; all logic on the rising edge.
- `rst  in  1`: synchronous, active-high reset; one clock, sampled on the `sys_clk` rising edge.
- `high_cnt  in  CNT_W`: buffered high-time count from the meter.
- `low_cnt  in  CNT_W`: buffered low-time count from the meter.
- `duty_out  out  DUTY_W`: last computed duty; reset 0.
- `duty_valid  out  1`: one-cycle pulse when `duty_out` updates; reset 0.
- `div_zero  out  1`: set with a result whose denominator was 0; held until the next result; reset 0.
- `busy  out  1`: high while in LOAD or DIV; reset 0.

## Operation
- The block keeps captured registers `cap_hi` and `cap_lo` (reset 0).
  - In IDLE, if `{high_cnt,low_cnt} != {cap_hi,cap_lo}`, capture both inputs and go to LOAD.
  - Otherwise stay in IDLE.
- Input changes while busy are ignored. On return to IDLE the inputs are compared again, so the latest pair is always computed. Intermediate pairs may be skipped.
- LOAD:
  - den = cap_hi + cap_lo, width CNT_W+1 with no overflow.
  - num = cap_hi·SCALE, width NUM_W = CNT_W+10 for the default SCALE; computed as a constant multiply.
  - If den == 0, go to DONE with quotient 0 and the zero flag set.
  - Otherwise clear the remainder, set the iteration counter to NUM_W and go to DIV.
- DIV: one restoring step per cycle, MSB first.
  - rem = {rem, num[msb]}; shift num left.
  - If rem ≥ den, subtract den and shift in quotient bit 1; otherwise shift in 0.
  - The counter decrements each step; when the NUM_W-th step completes, go to DONE.
- DONE:
  - `duty_out` = quotient saturated to 2^DUTY_W−1.
  - `div_zero` = zero flag.
  - Pulse `duty_valid`, then return to IDLE.
- States: IDLE → LOAD → DIV (×NUM_W) → DONE → IDLE, or IDLE → LOAD → DONE when den == 0.
- With the rounding macro undefined, the result is truncated.
- Result never exceeds SCALE when high ≤ high+low; saturation is a guard only.

## Timing
- Capture at edge E0. LOAD at E1. DIV steps at E2..E(NUM_W+1). DONE at E(NUM_W+2).
- `duty_out`, `div_zero` and `duty_valid` are registered at that DONE edge.
- Default latency: 44 cycles from the capture edge to `duty_valid` high.
- For den == 0: `duty_valid` goes high after E2.
- `busy` is high from the cycle after E0 up to and including the DIV cycles. It is low in the `duty_valid` cycle.
- Earliest next capture is the edge after DONE.
- Reset asserted in any state:
  - next edge forces IDLE;
  - all outputs and captured registers return to 0;
  - any in-flight result is discarded and no `duty_valid` is issued.
- After reset, inputs of 0/0 match the captured values, so no computation starts.

## Configuration
- `DUTY_CYCLE_CALC_ROUND_EN` defined: LOAD adds den>>1 to num, so the result is rounded to nearest with ties up. num width grows by 1 bit; latency is +1 cycle.
- `DUTY_CYCLE_CALC_ROUND_EN` undefined: truncating division, timing as stated above.

## Structure
- Package `duty_meter_pkg` holds:
  - the state enum (IDLE, LOAD, DIV, DONE);
  - default `CNT_W`, `SCALE` and `DUTY_W` constants;
  - a function that derives NUM_W from CNT_W and SCALE.
- Sub-module `serial_divider`: start/busy/done handshake, parameterised numerator and denominator widths, one quotient bit per cycle.
- The top level owns change detection, LOAD arithmetic, saturation and the output registers.

## Test plan
- high=50, low=50 → after 44 cycles `duty_valid` pulses once, `duty_out`=500, `div_zero`=0.
- high=1, low=2 → 333 in both builds. high=2, low=1 → 666 truncating, 667 with `DUTY_CYCLE_CALC_ROUND_EN`.
- high=0, low=0 after a nonzero pair → `duty_out`=0, `div_zero`=1, `duty_valid` 2 cycles after capture.
- high=25, low=75; change to 90/10 at cycle 10 of DIV → first result 250. Then a new capture, and 900 with a second pulse.
- Assert `rst` mid-DIV → outputs 0 the next cycle, no `duty_valid`. Inputs held at 7/3 → recomputed to 700 after release.
- high=0xFFFFFFFF, low=0 → `duty_out`=1000, no overflow, no saturation artefact.
